// File: rtl/decode_stage_hz.sv
// RV32I-subset decode stage with register file and ID/EX register (handshake, load-use bubble, flush).
// Define DECODE_BYPASS_EN for register-file write-through; default build returns the stored value.
module decode_stage_hz #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic              ValidD,
    output logic              ReadyD,
    input  logic              ReadyE,
    input  logic              FlushE,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RDW,
    input  logic [XLEN-1:0]   ResultW,
    output logic              ValidE,
    output logic              RegWriteE,
    output logic              ALUSrcE,
    output logic              MemWriteE,
    output logic              ResultSrcE,
    output logic              BranchE,
    output logic              IllegalE,
    output logic [2:0]        ALUControlE,
    output logic [XLEN-1:0]   RD1_E,
    output logic [XLEN-1:0]   RD2_E,
    output logic [XLEN-1:0]   Imm_Ext_E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [REG_AW-1:0] RS1_E,
    output logic [REG_AW-1:0] RS2_E,
    output logic [REG_AW-1:0] RD_E
);

    localparam int unsigned DEPTH = 1 << REG_AW;

    typedef enum logic [6:0] {
        OP_LW  = 7'b0000011,
        OP_SW  = 7'b0100011,
        OP_R   = 7'b0110011,
        OP_I   = 7'b0010011,
        OP_BEQ = 7'b1100011
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              alu_src;
        logic              mem_write;
        logic              result_src;
        logic              branch;
        logic              illegal;
        logic [2:0]        alu_ctrl;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } stage_t;

    function automatic logic [2:0] alu_from_funct3(input logic [2:0] funct3, input logic sub);
        case (funct3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    logic [XLEN-1:0]   regs [DEPTH];
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_s;
    logic [XLEN-1:0]   imm_b;
    logic              rs2_used;
    logic              load_use;
    logic              advance;
    stage_t            dec;
    stage_t            e_q;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rd     = InstrD[7 +: REG_AW];
    assign rs1    = InstrD[15 +: REG_AW];
    assign rs2    = InstrD[20 +: REG_AW];

    assign imm_i = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
    assign imm_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign imm_b = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWriteW && RDW != '0) begin
            regs[RDW] <= ResultW;
        end
    end

    always_comb begin
        rd1 = (rs1 == '0) ? '0 : regs[rs1];
        rd2 = (rs2 == '0) ? '0 : regs[rs2];
`ifdef DECODE_BYPASS_EN
        if (RegWriteW && RDW != '0 && RDW == rs1) rd1 = ResultW;
        if (RegWriteW && RDW != '0 && RDW == rs2) rd2 = ResultW;
`endif
    end

    always_comb begin
        dec          = '0;
        dec.valid    = ValidD;
        dec.rd1      = rd1;
        dec.rd2      = rd2;
        dec.pc       = PCD;
        dec.pc_plus4 = PCPlus4D;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = rd;
        case (opcode)
            OP_LW: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 1'b1;
                dec.imm        = imm_i;
                dec.alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = imm_s;
                dec.alu_ctrl  = ALU_ADD;
            end
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = alu_from_funct3(funct3, InstrD[30]);
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = imm_i;
                dec.alu_ctrl  = alu_from_funct3(funct3, 1'b0);
            end
            OP_BEQ: begin
                dec.branch   = 1'b1;
                dec.imm      = imm_b;
                dec.alu_ctrl = ALU_SUB;
            end
            default: dec.illegal = 1'b1;
        endcase
        // An empty slot must never look like a real instruction downstream.
        if (!ValidD) begin
            dec.reg_write  = 1'b0;
            dec.alu_src    = 1'b0;
            dec.mem_write  = 1'b0;
            dec.result_src = 1'b0;
            dec.branch     = 1'b0;
            dec.illegal    = 1'b0;
            dec.alu_ctrl   = '0;
        end
    end

    always_comb begin
        rs2_used = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ);
        load_use = ValidD && e_q.valid && e_q.result_src && e_q.reg_write &&
                   (e_q.rd != '0) &&
                   ((e_q.rd == rs1) || ((e_q.rd == rs2) && rs2_used));
        advance  = !e_q.valid || ReadyE;
        ReadyD   = FlushE || (!load_use && advance);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
        end else if (FlushE || (advance && load_use)) begin
            e_q <= '0;
        end else if (advance) begin
            e_q <= dec;
        end
    end

    assign ValidE      = e_q.valid;
    assign RegWriteE   = e_q.reg_write;
    assign ALUSrcE     = e_q.alu_src;
    assign MemWriteE   = e_q.mem_write;
    assign ResultSrcE  = e_q.result_src;
    assign BranchE     = e_q.branch;
    assign IllegalE    = e_q.illegal;
    assign ALUControlE = e_q.alu_ctrl;
    assign RD1_E       = e_q.rd1;
    assign RD2_E       = e_q.rd2;
    assign Imm_Ext_E   = e_q.imm;
    assign PCE         = e_q.pc;
    assign PCPlus4E    = e_q.pc_plus4;
    assign RS1_E       = e_q.rs1;
    assign RS2_E       = e_q.rs2;
    assign RD_E        = e_q.rd;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Randomized self-checking bench for decode_stage_hz against a behavioural model of the stage.
module tb_decode_stage_hz;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       InstrD = '0;
    logic [XLEN-1:0]   PCD = '0, PCPlus4D = '0;
    logic              ValidD = 1'b0, ReadyE = 1'b0, FlushE = 1'b0, RegWriteW = 1'b0;
    logic [REG_AW-1:0] RDW = '0;
    logic [XLEN-1:0]   ResultW = '0;
    logic              ReadyD, ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, IllegalE;
    logic [2:0]        ALUControlE;
    logic [XLEN-1:0]   RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [REG_AW-1:0] RS1_E, RS2_E, RD_E;

    decode_stage_hz #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .ReadyD(ReadyD), .ReadyE(ReadyE), .FlushE(FlushE),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .IllegalE(IllegalE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rw, asrc, mw, rsrc, br, ill;
        logic [2:0]  alu;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
    } mstate_t;

    mstate_t     m;
    logic [31:0] mregs [32];
    logic [2:0]  f3_alu [8] = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 3'b000, 3'b011, 3'b010};
    int          n_checks = 0;
    int          n_errors = 0;
    logic        last_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic mstate_t zero_state();
        mstate_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
`ifdef DECODE_BYPASS_EN
        if (RegWriteW && RDW == idx) return ResultW;
`endif
        return mregs[idx];
    endfunction

    // Expected E contents if the current D instruction were accepted.
    function automatic mstate_t model_decode();
        mstate_t s;
        int v;
        logic [6:0] op;
        s = zero_state();
        op = InstrD[6:0];
        s.valid = ValidD;
        s.pc = PCD;
        s.pc4 = PCPlus4D;
        s.rs1 = InstrD[19:15];
        s.rs2 = InstrD[24:20];
        s.rd  = InstrD[11:7];
        s.rd1 = mread(s.rs1);
        s.rd2 = mread(s.rs2);
        if (op == 7'b0000011) begin
            s.rw = 1; s.asrc = 1; s.rsrc = 1;
            v = $signed(InstrD[31:20]); s.imm = v;
        end else if (op == 7'b0100011) begin
            s.mw = 1; s.asrc = 1;
            v = $signed({InstrD[31:25], InstrD[11:7]}); s.imm = v;
        end else if (op == 7'b0110011) begin
            s.rw = 1;
            s.alu = f3_alu[InstrD[14:12]];
            if (InstrD[14:12] == 3'b000 && InstrD[30]) s.alu = 3'b001;
        end else if (op == 7'b0010011) begin
            s.rw = 1; s.asrc = 1;
            s.alu = f3_alu[InstrD[14:12]];
            v = $signed(InstrD[31:20]); s.imm = v;
        end else if (op == 7'b1100011) begin
            s.br = 1; s.alu = 3'b001;
            v = $signed({InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0}); s.imm = v;
        end else begin
            s.ill = 1;
        end
        if (!ValidD) begin
            s.rw = 0; s.asrc = 0; s.mw = 0; s.rsrc = 0; s.br = 0; s.ill = 0; s.alu = 0;
        end
        return s;
    endfunction

    function automatic logic model_lu();
        logic [6:0] op;
        logic uses_rs2;
        op = InstrD[6:0];
        uses_rs2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
        return ValidD && m.valid && m.rsrc && m.rw && m.rd != 0 &&
               (m.rd == InstrD[19:15] || (uses_rs2 && m.rd == InstrD[24:20]));
    endfunction

    task automatic compare_e(input string ctx);
        chk({ctx, ".ValidE"}, ValidE, m.valid);
        chk({ctx, ".RegWriteE"}, RegWriteE, m.rw);
        chk({ctx, ".ALUSrcE"}, ALUSrcE, m.asrc);
        chk({ctx, ".MemWriteE"}, MemWriteE, m.mw);
        chk({ctx, ".ResultSrcE"}, ResultSrcE, m.rsrc);
        chk({ctx, ".BranchE"}, BranchE, m.br);
        chk({ctx, ".IllegalE"}, IllegalE, m.ill);
        chk({ctx, ".ALUControlE"}, ALUControlE, m.alu);
        chk({ctx, ".RD1_E"}, RD1_E, m.rd1);
        chk({ctx, ".RD2_E"}, RD2_E, m.rd2);
        chk({ctx, ".Imm_Ext_E"}, Imm_Ext_E, m.imm);
        chk({ctx, ".PCE"}, PCE, m.pc);
        chk({ctx, ".PCPlus4E"}, PCPlus4E, m.pc4);
        chk({ctx, ".RS1_E"}, RS1_E, m.rs1);
        chk({ctx, ".RS2_E"}, RS2_E, m.rs2);
        chk({ctx, ".RD_E"}, RD_E, m.rd);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input string ctx, input logic [31:0] instr, input logic vd, input logic re,
                        input logic fl, input logic rw, input logic [4:0] rdw, input logic [31:0] res);
        mstate_t nxt;
        logic lu, adv;
        logic [31:0] pc;
        pc = $urandom;
        InstrD = instr; ValidD = vd; ReadyE = re; FlushE = fl;
        RegWriteW = rw; RDW = rdw; ResultW = res;
        PCD = pc; PCPlus4D = pc + 32'd4;
        #1;
        lu  = model_lu();
        adv = !m.valid || ReadyE;
        last_ready = ReadyD;
        chk({ctx, ".ReadyD"}, ReadyD, FlushE || (!lu && adv));
        @(posedge clk);
        nxt = model_decode();
        if (FlushE || (adv && lu)) m = zero_state();
        else if (adv) m = nxt;
        if (RegWriteW && RDW != 0) mregs[RDW] = ResultW;
        #1;
        compare_e(ctx);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w[6:0] = 7'b0000011;
            1: w[6:0] = 7'b0100011;
            2: w[6:0] = 7'b0110011;
            3: w[6:0] = 7'b0010011;
            4: w[6:0] = 7'b1100011;
            default: ;
        endcase
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        m = zero_state();
        @(negedge clk);
        @(negedge clk);
        compare_e("reset");
        chk("reset.ReadyD", ReadyD, 1'b1);
        rst = 1'b0;

        // addi x1,x0,5 (also writes x5=0x1234 via W) then add x2,x1,x1
        step("addi", 32'h00500093, 1, 1, 0, 1, 5'd5, 32'h0000_1234);
        chk("addi.valid", ValidE, 1'b1);
        chk("addi.imm", Imm_Ext_E, 32'd5);
        chk("addi.alu", ALUControlE, 3'b000);
        step("add", 32'h00108133, 1, 1, 0, 1, 5'd1, 32'd5);
        chk("add.valid", ValidE, 1'b1);
        chk("add.rs1", RS1_E, 5'd1);
        chk("add.rs2", RS2_E, 5'd1);

        // lw x3,0(x0) then sub x4,x3,x1: one bubble
        step("lw", 32'h00000183, 1, 1, 0, 0, 5'd0, 32'd0);
        step("sub_stall", 32'h40118233, 1, 1, 0, 0, 5'd0, 32'd0);
        chk("lu.readyd", last_ready, 1'b0);
        chk("lu.bubble", ValidE, 1'b0);
        step("sub_go", 32'h40118233, 1, 1, 0, 0, 5'd0, 32'd0);
        chk("lu.readyd_after", last_ready, 1'b1);
        chk("sub.valid", ValidE, 1'b1);
        chk("sub.alu", ALUControlE, 3'b001);

        // beq x0,x0,-4, then flush while ReadyE=0 with add in D
        step("beq", 32'hFE000EE3, 1, 1, 0, 0, 5'd0, 32'd0);
        chk("beq.imm", Imm_Ext_E, 32'hFFFF_FFFC);
        chk("beq.branch", BranchE, 1'b1);
        step("flush", 32'h00108133, 1, 0, 1, 0, 5'd0, 32'd0);
        chk("flush.readyd", last_ready, 1'b1);
        chk("flush.valid", ValidE, 1'b0);
        step("post_flush", 32'h0, 0, 1, 0, 0, 5'd0, 32'd0);
        chk("post_flush.valid", ValidE, 1'b0);

        // same-cycle write/read of x7
        step("bypass", 32'h00038433, 1, 1, 0, 1, 5'd7, 32'hDEAD_BEEF);
`ifdef DECODE_BYPASS_EN
        chk("bypass.rd1", RD1_E, 32'hDEAD_BEEF);
`else
        chk("bypass.rd1", RD1_E, 32'h0);
`endif

        step("illegal", 32'h0000007F, 1, 1, 0, 0, 5'd0, 32'd0);
        chk("illegal.flag", IllegalE, 1'b1);
        chk("illegal.regwrite", RegWriteE, 1'b0);

        // Stall with ReadyE=0, then async reset mid-cycle
        step("hold_lw", 32'h00000183, 1, 1, 0, 0, 5'd0, 32'd0);
        step("hold", 32'h00500093, 1, 0, 0, 0, 5'd0, 32'd0);
        chk("hold.readyd", last_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        m = zero_state();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        compare_e("async_rst");
        chk("async_rst.ReadyD", ReadyD, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        step("read_x5", 32'h00028333, 1, 1, 0, 0, 5'd0, 32'd0);
        chk("read_x5.rd1", RD1_E, 32'h0);

        for (int n = 0; n < 400; n++) begin
            step("rand", rand_instr(), ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
